// File: rtl/mem_access_unit.sv
// M-stage load/store unit: lane select, store replication, load extension,
// alignment exceptions and a req/ack memory handshake with timeout.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              bus_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] cnt;

  logic              isLoad;
  logic              isStore;
  logic              isLegal;
  logic              signExt;
  logic [1:0]        accSize;
  logic              misaligned;
  logic              accept;
  logic [1:0]        byteLane;
  logic              halfHi;
  logic [3:0]        weNext;
  logic [31:0]       wdataNext;

  logic              loadReg;
  logic              signReg;
  logic [1:0]        sizeReg;
  logic [1:0]        laneReg;
  logic              halfHiReg;
  logic [7:0]        selByte;
  logic [15:0]       selHalf;
  logic [31:0]       loadFmt;

  logic              stallAcc;
  logic              respValidQ;
  logic [31:0]       respRdataQ;
  logic              excAdelQ;
  logic              excAdesQ;
  logic [ADDR_W-1:0] badVaddrQ;
  logic              busErrQ;
  logic              memEnQ;
  logic [3:0]        memWeQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [31:0]       memWdataQ;

  // Opcode decode into direction, access size and extension mode
  always_comb begin
    isLoad  = 1'b0;
    isStore = 1'b0;
    signExt = 1'b0;
    accSize = SZ_B;
    case (req_op)
      OP_LB: begin
        isLoad  = 1'b1;
        signExt = 1'b1;
      end
      OP_LH: begin
        isLoad  = 1'b1;
        signExt = 1'b1;
        accSize = SZ_H;
      end
      OP_LW: begin
        isLoad  = 1'b1;
        accSize = SZ_W;
      end
      OP_LBU: isLoad = 1'b1;
      OP_LHU: begin
        isLoad  = 1'b1;
        accSize = SZ_H;
      end
      OP_SB: isStore = 1'b1;
      OP_SH: begin
        isStore = 1'b1;
        accSize = SZ_H;
      end
      OP_SW: begin
        isStore = 1'b1;
        accSize = SZ_W;
      end
      default: ;
    endcase
  end

  assign isLegal = isLoad | isStore;

  assign misaligned =
    ((accSize == SZ_H) && req_addr[0]) ||
    ((accSize == SZ_W) && (req_addr[1:0] != 2'b00));

  assign accept = (state == IDLE) && req_valid &&
                  isLegal && !misaligned;

  // Big-endian mirrors the lane index: 3-a == a^3 on two bits
  assign byteLane = req_addr[1:0] ^ {2{BIG_ENDIAN}};
  assign halfHi   = req_addr[1] ^ BIG_ENDIAN;

  // Byte enables and replicated write data for the request
  always_comb begin
    weNext    = 4'b1111;
    wdataNext = req_wdata;
    case (accSize)
      SZ_B: begin
        weNext    = 4'b0001 << byteLane;
        wdataNext = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        weNext    = halfHi ? 4'b1100 : 4'b0011;
        wdataNext = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick and extend the addressed lane out of the returned word
  always_comb begin
    case (laneReg)
      2'd0:    selByte = mem_rdata[7:0];
      2'd1:    selByte = mem_rdata[15:8];
      2'd2:    selByte = mem_rdata[23:16];
      default: selByte = mem_rdata[31:24];
    endcase
    selHalf = halfHiReg ? mem_rdata[31:16] : mem_rdata[15:0];
    case (sizeReg)
      SZ_B:    loadFmt = {{24{signReg & selByte[7]}}, selByte};
      SZ_H:    loadFmt = {{16{signReg & selHalf[15]}}, selHalf};
      default: loadFmt = mem_rdata;
    endcase
  end

  // Access FSM with registered memory-side and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      loadReg    <= 1'b0;
      signReg    <= 1'b0;
      sizeReg    <= SZ_B;
      laneReg    <= 2'd0;
      halfHiReg  <= 1'b0;
      respValidQ <= 1'b0;
      respRdataQ <= '0;
      excAdelQ   <= 1'b0;
      excAdesQ   <= 1'b0;
      badVaddrQ  <= '0;
      busErrQ    <= 1'b0;
      memEnQ     <= 1'b0;
      memWeQ     <= 4'b0000;
      memAddrQ   <= '0;
      memWdataQ  <= '0;
    end else begin
      respValidQ <= 1'b0;
      excAdelQ   <= 1'b0;
      excAdesQ   <= 1'b0;
      busErrQ    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && isLegal) begin
            if (misaligned) begin
              excAdelQ  <= isLoad;
              excAdesQ  <= isStore;
              badVaddrQ <= req_addr;
            end else begin
              memEnQ    <= 1'b1;
              memWeQ    <= isStore ? weNext : 4'b0000;
              memAddrQ  <= {req_addr[ADDR_W-1:2], 2'b00};
              memWdataQ <= wdataNext;
              loadReg   <= isLoad;
              signReg   <= signExt;
              sizeReg   <= accSize;
              laneReg   <= byteLane;
              halfHiReg <= halfHi;
              cnt       <= '0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            memEnQ     <= 1'b0;
            memWeQ     <= 4'b0000;
            respValidQ <= 1'b1;
            if (loadReg) respRdataQ <= loadFmt;
            state      <= RESP;
          end else if (cnt == CNT_LAST) begin
            memEnQ  <= 1'b0;
            memWeQ  <= 4'b0000;
            busErrQ <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stallAcc   = (state == ACCESS);
  assign stall      = stallAcc | accept;
  assign resp_valid = respValidQ;
  assign resp_rdata = respRdataQ;
  assign exc_adel   = excAdelQ;
  assign exc_ades   = excAdesQ;
  assign badvaddr   = badVaddrQ;
  assign bus_err    = busErrQ;
  assign mem_en     = memEnQ;
  assign mem_we     = memWeQ;
  assign mem_addr   = memAddrQ;
  assign mem_wdata  = memWdataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a little-endian instance with a short
// timeout and a big-endian instance share one request/memory bus.
module tb_mem_access_unit;

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic [5:0]  reqOp;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [31:0] memRdata;
  logic        memAck;

  logic        stallLe, respValidLe, excAdelLe, excAdesLe;
  logic        busErrLe, memEnLe;
  logic [31:0] respRdataLe, badVaddrLe, memAddrLe, memWdataLe;
  logic [3:0]  memWeLe;

  logic        stallBe, respValidBe, excAdelBe, excAdesBe;
  logic        busErrBe, memEnBe;
  logic [31:0] respRdataBe, badVaddrBe, memAddrBe, memWdataBe;
  logic [3:0]  memWeBe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W(32), .TIMEOUT(4), .BIG_ENDIAN(1'b0)
  ) uLe (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_op(reqOp),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .stall(stallLe), .resp_valid(respValidLe),
    .resp_rdata(respRdataLe), .exc_adel(excAdelLe),
    .exc_ades(excAdesLe), .badvaddr(badVaddrLe),
    .bus_err(busErrLe), .mem_en(memEnLe),
    .mem_we(memWeLe), .mem_addr(memAddrLe),
    .mem_wdata(memWdataLe), .mem_rdata(memRdata),
    .mem_ack(memAck)
  );

  mem_access_unit #(
    .ADDR_W(32), .TIMEOUT(255), .BIG_ENDIAN(1'b1)
  ) uBe (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_op(reqOp),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .stall(stallBe), .resp_valid(respValidBe),
    .resp_rdata(respRdataBe), .exc_adel(excAdelBe),
    .exc_ades(excAdesBe), .badvaddr(badVaddrBe),
    .bus_err(busErrBe), .mem_en(memEnBe),
    .mem_we(memWeBe), .mem_addr(memAddrBe),
    .mem_wdata(memWdataBe), .mem_rdata(memRdata),
    .mem_ack(memAck)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackAt;
    logic [3:0]  weLe;
    logic [3:0]  weBe;
    logic [31:0] wd;
    logic [31:0] rdLe;
    logic [31:0] rdBe;
  } vecT;

  typedef struct {
    int          stallCyc;
    int          respAt;
    logic        en1;
    logic [3:0]  weLe;
    logic [3:0]  weBe;
    logic [31:0] wd;
    logic [31:0] maddr;
    logic [31:0] rdLe;
    logic [31:0] rdBe;
  } resT;

  localparam int NV = 11;
  vecT vecs[NV];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic anyOutLe();
    return |{stallLe, respValidLe, respRdataLe, excAdelLe,
             excAdesLe, badVaddrLe, busErrLe, memEnLe,
             memWeLe, memAddrLe, memWdataLe};
  endfunction

  function automatic logic anyOutBe();
    return |{stallBe, respValidBe, respRdataBe, excAdelBe,
             excAdesBe, badVaddrBe, busErrBe, memEnBe,
             memWeBe, memAddrBe, memWdataBe};
  endfunction

  // One accepted access; ack is raised in ACCESS cycle ackAt (>=1)
  task automatic runAcc(input logic [5:0] op,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [31:0] rdata,
                        input int ackAt,
                        output resT r);
    r.stallCyc = 0;
    r.respAt   = -1;
    r.en1      = 1'b0;
    r.weLe     = 4'h0;
    r.weBe     = 4'h0;
    r.wd       = '0;
    r.maddr    = '0;
    r.rdLe     = '0;
    r.rdBe     = '0;
    @(negedge clk);
    reqValid = 1'b1;
    reqOp    = op;
    reqAddr  = addr;
    reqWdata = wdata;
    memRdata = rdata;
    for (int c = 0; c <= ackAt + 2; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) reqValid = 1'b0;
      memAck = (c == ackAt);
      #1;
      if (stallLe) r.stallCyc++;
      if (c == 1) begin
        r.en1   = memEnLe;
        r.weLe  = memWeLe;
        r.weBe  = memWeBe;
        r.wd    = memWdataLe;
        r.maddr = memAddrLe;
      end
      if (respValidLe && r.respAt < 0) begin
        r.respAt = c;
        r.rdLe   = respRdataLe;
        r.rdBe   = respRdataBe;
      end
    end
    memAck = 1'b0;
  endtask

  initial begin
    resT r;
    int enCnt, errCnt, errAt, rvCnt, stCnt;

    vecs[0]  = '{LB,  32'h1003, 32'h0,        32'h80FF_1234, 3,
                 4'h0, 4'h0, 32'h0,        32'hFFFF_FF80, 32'h0000_0034};
    vecs[1]  = '{LBU, 32'h1003, 32'h0,        32'h80FF_1234, 1,
                 4'h0, 4'h0, 32'h0,        32'h0000_0080, 32'h0000_0034};
    vecs[2]  = '{SH,  32'h2002, 32'h0000_BEEF, 32'hDEAD_BEEF, 1,
                 4'hC, 4'h3, 32'hBEEF_BEEF, 32'h0000_0080, 32'h0000_0034};
    vecs[3]  = '{LH,  32'h0000, 32'h0,        32'h8001_0002, 1,
                 4'h0, 4'h0, 32'h0,        32'h0000_0002, 32'hFFFF_8001};
    vecs[4]  = '{SB,  32'h0000, 32'h1234_56A5, 32'h0,        2,
                 4'h1, 4'h8, 32'hA5A5_A5A5, 32'h0000_0002, 32'hFFFF_8001};
    vecs[5]  = '{LHU, 32'h5006, 32'h0,        32'h9ABC_1357, 1,
                 4'h0, 4'h0, 32'h0,        32'h0000_9ABC, 32'h0000_1357};
    vecs[6]  = '{LW,  32'h6008, 32'h0,        32'hCAFE_F00D, 2,
                 4'h0, 4'h0, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[7]  = '{SW,  32'h700C, 32'h1122_3344, 32'h5555_AAAA, 1,
                 4'hF, 4'hF, 32'h1122_3344, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[8]  = '{LB,  32'h8001, 32'h0,        32'h0085_7F00, 1,
                 4'h0, 4'h0, 32'h0,        32'h0000_007F, 32'hFFFF_FF85};
    vecs[9]  = '{SB,  32'h9002, 32'h0000_00C3, 32'h0,        1,
                 4'h4, 4'h2, 32'hC3C3_C3C3, 32'h0000_007F, 32'hFFFF_FF85};
    vecs[10] = '{LH,  32'hA002, 32'h0,        32'h8421_F00F, 1,
                 4'h0, 4'h0, 32'h0,        32'hFFFF_8421, 32'hFFFF_F00F};

    rst      = 1'b1;
    reqValid = 1'b0;
    reqOp    = '0;
    reqAddr  = '0;
    reqWdata = '0;
    memRdata = '0;
    memAck   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs_le", {31'b0, anyOutLe()}, 32'h0);
    chk("reset_outs_be", {31'b0, anyOutBe()}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      runAcc(vecs[i].op, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].ackAt, r);
      chk($sformatf("v%0d_stall", i), r.stallCyc, vecs[i].ackAt + 1);
      chk($sformatf("v%0d_resp_at", i), r.respAt, vecs[i].ackAt + 1);
      chk($sformatf("v%0d_en", i), {31'b0, r.en1}, 32'h1);
      chk($sformatf("v%0d_addr", i), r.maddr,
          vecs[i].addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_we_le", i), {28'b0, r.weLe},
          {28'b0, vecs[i].weLe});
      chk($sformatf("v%0d_we_be", i), {28'b0, r.weBe},
          {28'b0, vecs[i].weBe});
      if (vecs[i].op[3])
        chk($sformatf("v%0d_wdata", i), r.wd, vecs[i].wd);
      chk($sformatf("v%0d_rd_le", i), r.rdLe, vecs[i].rdLe);
      chk($sformatf("v%0d_rd_be", i), r.rdBe, vecs[i].rdBe);
      chk($sformatf("v%0d_en_off", i), {31'b0, memEnLe}, 32'h0);
    end

    // Misaligned load then misaligned store
    @(negedge clk);
    reqValid = 1'b1;
    reqOp    = LW;
    reqAddr  = 32'h3002;
    #1;
    chk("adel_stall", {31'b0, stallLe}, 32'h0);
    @(negedge clk);
    reqOp   = SH;
    reqAddr = 32'h3001;
    #1;
    chk("adel_pulse", {31'b0, excAdelLe}, 32'h1);
    chk("adel_no_ades", {31'b0, excAdesLe}, 32'h0);
    chk("adel_badv", badVaddrLe, 32'h3002);
    chk("adel_no_mem", {31'b0, memEnLe}, 32'h0);
    chk("ades_stall", {31'b0, stallLe}, 32'h0);
    @(negedge clk);
    reqValid = 1'b0;
    #1;
    chk("ades_pulse", {31'b0, excAdesLe}, 32'h1);
    chk("ades_no_adel", {31'b0, excAdelLe}, 32'h0);
    chk("ades_badv", badVaddrLe, 32'h3001);
    chk("ades_no_mem", {31'b0, memEnLe}, 32'h0);
    @(negedge clk);
    #1;
    chk("ades_one_cycle", {31'b0, excAdesLe}, 32'h0);
    chk("badv_held", badVaddrLe, 32'h3001);

    // Illegal op and a stray ack in IDLE are both ignored
    @(negedge clk);
    reqValid = 1'b1;
    reqOp    = 6'h22;
    reqAddr  = 32'h0;
    memAck   = 1'b1;
    #1;
    chk("illegal_stall", {31'b0, stallLe}, 32'h0);
    @(negedge clk);
    reqValid = 1'b0;
    memAck   = 1'b0;
    #1;
    chk("illegal_no_mem", {31'b0, memEnLe}, 32'h0);
    chk("illegal_no_exc", {30'b0, excAdelLe, excAdesLe}, 32'h0);
    chk("idle_ack_no_resp", {31'b0, respValidLe}, 32'h0);

    // Store that never gets acked times out on the LE instance
    enCnt  = 0;
    errCnt = 0;
    errAt  = -1;
    rvCnt  = 0;
    stCnt  = 0;
    @(negedge clk);
    reqValid = 1'b1;
    reqOp    = SW;
    reqAddr  = 32'h100;
    reqWdata = 32'h0F0F_0F0F;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) reqValid = 1'b0;
      #1;
      if (memEnLe) enCnt++;
      if (busErrLe) begin
        errCnt++;
        errAt = c;
      end
      if (respValidLe) rvCnt++;
      if (stallLe) stCnt++;
    end
    chk("to_en_cycles", enCnt, 4);
    chk("to_buserr_cnt", errCnt, 1);
    chk("to_buserr_at", errAt, 5);
    chk("to_no_resp", rvCnt, 0);
    chk("to_stall_cycles", stCnt, 5);
    chk("to_stall_off", {31'b0, stallLe}, 32'h0);

    // Reset while an access is outstanding, then a late ack
    @(negedge clk);
    reqValid = 1'b1;
    reqOp    = LW;
    reqAddr  = 32'h40;
    memRdata = 32'h1357_9BDF;
    @(negedge clk);
    reqValid = 1'b0;
    #1;
    chk("rst_pre_en", {31'b0, memEnLe}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_le", {31'b0, anyOutLe()}, 32'h0);
    chk("rst_mid_be", {31'b0, anyOutBe()}, 32'h0);
    @(negedge clk);
    memAck = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ack_no_resp", {31'b0, respValidLe}, 32'h0);
    @(negedge clk);
    memAck = 1'b0;
    #1;
    chk("rst_late_resp", {31'b0, respValidLe}, 32'h0);
    chk("rst_late_outs", {31'b0, anyOutLe()}, 32'h0);

    runAcc(LW, 32'h4, 32'h0, 32'h0BAD_F00D, 1, r);
    chk("post_rst_stall", r.stallCyc, 2);
    chk("post_rst_resp_at", r.respAt, 2);
    chk("post_rst_addr", r.maddr, 32'h4);
    chk("post_rst_rd_le", r.rdLe, 32'h0BAD_F00D);
    chk("post_rst_rd_be", r.rdBe, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised successor to the combinational memsel stage: handles MIPS load/store in the M stage against a memory with variable latency via a req/ack handshake. Performs byte-lane select, store data replication, load sign/zero extension and alignment checking (AdEL/AdES with bad address capture). Stalls the pipeline while an access is outstanding and raises a bus error on timeout. Sits between the datapath M stage and the data memory/bus.

Parameters:
ADDR_W, 32, width of address ports and badvaddr
TIMEOUT, 255, max ACCESS-state cycles without mem_ack before bus error (>=1)
BIG_ENDIAN, 0, 0 = little-endian lanes, 1 = big-endian lanes

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  M-stage memory instruction present
req_op  in  6  opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B
req_addr  in  ADDR_W  effective address (aluoutM)
req_wdata  in  32  store data from datapath
stall  out  1  hold M stage and earlier
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  formatted load data, valid with resp_valid
exc_adel  out  1  one-cycle pulse: misaligned load
exc_ades  out  1  one-cycle pulse: misaligned store
badvaddr  out  ADDR_W  faulting address, held until next exception
bus_err  out  1  one-cycle pulse: timeout
mem_en  out  1  memory request
mem_we  out  4  byte write enables (0 for loads)
mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read word
mem_ack  in  1  memory completion

Behaviour:
- Reset: state IDLE, timeout counter 0; all outputs 0 (stall, resp_valid, resp_rdata, exc_*, badvaddr, bus_err, mem_en, mem_we, mem_addr, mem_wdata).
- Illegal op (not in list) with req_valid: ignored, no access, no exception, stall 0.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; bytes always aligned.
- Lane k = addr[1:0] (LE) or 3-addr[1:0] (BE); byte k = bits 8k+7:8k.
- Stores: SB we=1<<k, wdata = byte replicated x4; SH we=0011 (k=0) or 1100 (k=2), wdata = half replicated x2; SW we=1111, wdata as-is.
- Loads: select lane byte/half from mem_rdata; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- FSM IDLE:
  - req_valid, legal, misaligned: registered exc_adel/exc_ades pulse next cycle, badvaddr <= req_addr, no memory access, stay IDLE; stall 0.
  - req_valid, legal, aligned: stall=1 combinationally this cycle; register mem_addr/we/wdata, mem_en <= 1, counter <= 0 -> ACCESS.
  - mem_ack in IDLE ignored.
- ACCESS: stall=1; mem_* held stable. Counter increments each cycle.
  - mem_ack: mem_en <= 0, mem_we <= 0; loads latch formatted resp_rdata (stores: resp_rdata unchanged) -> RESP.
  - no ack, counter = TIMEOUT-1: mem_en <= 0, bus_err pulse next cycle -> IDLE (pipeline released; no resp_valid).
  - ack wins over timeout in the same cycle.
- RESP: resp_valid=1, stall=0 for exactly one cycle -> IDLE. New request in the cycle after RESP accepted normally.
- Latency: zero-wait memory (ack in first ACCESS cycle) gives resp_valid 2 cycles after acceptance; stall high 2 cycles.
- req_* sampled only in IDLE; changes during ACCESS/RESP ignored.
- Reset mid-access: immediate abort, all outputs to reset values, late mem_ack ignored.

Test Plan:
- LE LB addr 0x1003, mem_rdata 0x80FF_1234, ack after 3 cycles -> mem_addr 0x1000, we 0000, stall 4 cycles, resp_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x2002 wdata 0x0000_BEEF, ack immediately -> mem_we 1100, mem_wdata 0xBEEF_BEEF, resp_valid pulse 2 cycles after request.
- LW addr 0x3002 -> no mem_en, exc_adel pulse, badvaddr 0x3002, stall 0; SH addr 0x3001 -> exc_ades, badvaddr 0x3001.
- TIMEOUT=4, SW with no ack -> mem_en high 4 cycles, bus_err pulse, no resp_valid, stall drops.
- BIG_ENDIAN=1, LH addr 0x0, mem_rdata 0x8001_0002 -> resp_rdata 0xFFFF_8001; SB addr 0x0 -> we 1000.
- Assert rst during ACCESS then ack -> all outputs 0, state IDLE, no resp_valid; next LW addr 0x4 completes normally.
